// File: rtl/clkdiv_pkg.sv
// Shared constants and types for the programmable clock divider bank.
package clkdiv_pkg;

    localparam int unsigned CLKDIV_MIN_RATIO = 2;
    localparam int unsigned CLKDIV_NCH       = 4;
    localparam int unsigned CLKDIV_DIVW      = 8;
    localparam int unsigned CLKDIV_RST_DIV   = 4;

    typedef logic [CLKDIV_DIVW-1:0] div_t;

    // Gate handshake states: counting, finishing the current period, parked.
    typedef enum logic [1:0] {
        GATE_RUN   = 2'd0,
        GATE_DRAIN = 2'd1,
        GATE_GATED = 2'd2
    } gate_state_t;

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: period counter, shadowed ratio, duty compare and
// registered clock/enable outputs. Optional gate handshake under CLKDIV_GATE_EN.
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int unsigned DIVW    = CLKDIV_DIVW,
    parameter int unsigned RST_DIV = CLKDIV_RST_DIV
) (
    input  logic            clki,
    input  logic            rst_n,
    input  logic            we,
    input  logic [DIVW-1:0] div,
    input  logic            sync,
`ifdef CLKDIV_GATE_EN
    input  logic            gate_req,
    output logic            gate_ack,
`endif
    output logic            pend,
    output logic            done,
    output logic            clko,
    output logic            ce,
    output logic            run
);

    localparam logic [DIVW-1:0] MIN_R   = DIVW'(CLKDIV_MIN_RATIO);
    localparam logic [DIVW-1:0] RST_R   = DIVW'(RST_DIV);
    localparam logic            RST_RUN = (RST_DIV >= CLKDIV_MIN_RATIO);

    logic [DIVW-1:0] live_q;
    logic [DIVW-1:0] shadow_q;
    logic [DIVW-1:0] cnt_q;

    logic [DIVW-1:0] apply_val_c;
    logic [DIVW-1:0] live_nxt_c;
    logic [DIVW-1:0] cnt_nxt_c;
    logic            running_c;
    logic            active_c;
    logic            at_end_c;
    logic            hold_c;
    logic            release_c;
    logic            sync_c;
    logic            apply_c;

`ifdef CLKDIV_GATE_EN
    gate_state_t     gst_q;
`endif

    // Period boundary detection, shadow apply decision and next counter value.
    always_comb begin
        hold_c    = 1'b0;
        release_c = 1'b0;
`ifdef CLKDIV_GATE_EN
        hold_c    = (gst_q == GATE_GATED);
        release_c = hold_c && !gate_req;
`endif
        running_c = (live_q >= MIN_R);
        active_c  = running_c && !hold_c;
        at_end_c  = running_c && (cnt_q == live_q - DIVW'(1));
        sync_c    = sync && active_c;

        // A write coinciding with sync is applied by that sync directly.
        apply_c = 1'b0;
        if (sync_c) begin
            apply_c = pend || we;
        end else if (hold_c) begin
            apply_c = pend && release_c;
        end else begin
            apply_c = pend && (!running_c || at_end_c);
        end

        apply_val_c = (sync_c && we) ? div : shadow_q;
        live_nxt_c  = apply_c ? apply_val_c : live_q;
        cnt_nxt_c   = (active_c && !sync_c && !at_end_c) ? cnt_q + DIVW'(1) : '0;
    end

    // Channel state and registered outputs (one cycle behind cnt).
    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            live_q   <= RST_R;
            shadow_q <= RST_R;
            cnt_q    <= '0;
            pend     <= 1'b0;
            done     <= 1'b0;
            clko     <= 1'b0;
            ce       <= 1'b0;
            run      <= RST_RUN;
`ifdef CLKDIV_GATE_EN
            gst_q    <= GATE_RUN;
            gate_ack <= 1'b0;
`endif
        end else begin
            live_q <= live_nxt_c;
            cnt_q  <= cnt_nxt_c;
            if (we) begin
                shadow_q <= div;
            end
            // A write landing on an apply cycle stays pending for the next boundary.
            if (sync_c) begin
                pend <= 1'b0;
            end else if (we) begin
                pend <= 1'b1;
            end else if (apply_c) begin
                pend <= 1'b0;
            end
            done <= apply_c;
            run  <= (live_nxt_c >= MIN_R);
            ce   <= active_c && (cnt_q == '0);
            clko <= active_c && (cnt_q < (live_q >> 1));
`ifdef CLKDIV_GATE_EN
            case (gst_q)
                GATE_RUN: begin
                    if (gate_req && running_c) begin
                        gst_q <= at_end_c ? GATE_GATED : GATE_DRAIN;
                    end
                end
                GATE_DRAIN: begin
                    if (!gate_req) begin
                        gst_q <= GATE_RUN;
                    end else if (at_end_c || !running_c) begin
                        gst_q <= GATE_GATED;
                    end
                end
                GATE_GATED: begin
                    if (!gate_req) begin
                        gst_q <= GATE_RUN;
                    end
                end
                default: gst_q <= GATE_RUN;
            endcase
            gate_ack <= (gst_q == GATE_GATED) && gate_req;
`endif
        end
    end

endmodule

// File: rtl/clkdiv_bank.sv
// N-channel programmable clock divider bank with glitch-free retune and
// global phase re-align. Optional per-channel gating via macro CLKDIV_GATE_EN.
module clkdiv_bank
    import clkdiv_pkg::*;
#(
    parameter int unsigned NCH     = CLKDIV_NCH,
    parameter int unsigned DIVW    = CLKDIV_DIVW,
    parameter int unsigned RST_DIV = CLKDIV_RST_DIV
) (
    input  logic                                  clki,
    input  logic                                  rst_n,
    input  logic                                  cfg_we,
    input  logic [$clog2(NCH > 1 ? NCH : 2)-1:0]  cfg_ch,
    input  logic [DIVW-1:0]                       cfg_div,
    input  logic                                  sync_start,
`ifdef CLKDIV_GATE_EN
    input  logic [NCH-1:0]                        gate_req,
    output logic [NCH-1:0]                        gate_ack,
`endif
    output logic [NCH-1:0]                        cfg_pend,
    output logic [NCH-1:0]                        cfg_done,
    output logic [NCH-1:0]                        div_clko,
    output logic [NCH-1:0]                        div_ce,
    output logic [NCH-1:0]                        ch_run
);

    localparam int unsigned CHW = $clog2(NCH > 1 ? NCH : 2);

    logic [NCH-1:0] we_c;

    // Channel select decode; out-of-range channel numbers match nothing.
    always_comb begin
        we_c = '0;
        for (int i = 0; i < NCH; i++) begin
            we_c[i] = cfg_we && (cfg_ch == CHW'(i));
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        clkdiv_chan #(
            .DIVW    (DIVW),
            .RST_DIV (RST_DIV)
        ) u_chan (
            .clki     (clki),
            .rst_n    (rst_n),
            .we       (we_c[g]),
            .div      (cfg_div),
            .sync     (sync_start),
`ifdef CLKDIV_GATE_EN
            .gate_req (gate_req[g]),
            .gate_ack (gate_ack[g]),
`endif
            .pend     (cfg_pend[g]),
            .done     (cfg_done[g]),
            .clko     (div_clko[g]),
            .ce       (div_ce[g]),
            .run      (ch_run[g])
        );
    end

endmodule

// File: tb/tb_clkdiv_bank.sv
// Self-checking bench for clkdiv_bank against a time-based reference model.
module tb_clkdiv_bank;

    localparam int NCH = 4;

    logic       clki = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_ch = 2'd0;
    logic [7:0] cfg_div = 8'd0;
    logic       sync_start = 1'b0;
    logic [3:0] cfg_pend, cfg_done, div_clko, div_ce, ch_run;
`ifdef CLKDIV_GATE_EN
    logic [3:0] gate_req = 4'd0;
    logic [3:0] gate_ack;
`endif

    clkdiv_bank dut (
        .clki       (clki),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
        .sync_start (sync_start),
`ifdef CLKDIV_GATE_EN
        .gate_req   (gate_req),
        .gate_ack   (gate_ack),
`endif
        .cfg_pend   (cfg_pend),
        .cfg_done   (cfg_done),
        .div_clko   (div_clko),
        .div_ce     (div_ce),
        .ch_run     (ch_run)
    );

    always #5 clki = ~clki;

    int checks = 0;
    int errors = 0;

    // Reference model: each running channel's phase is (edge index - period start) mod ratio.
    int unsigned m_r[NCH];
    int unsigned m_sh[NCH];
    int unsigned m_t0[NCH];
    bit          m_pend[NCH];
    int unsigned cyc;
    logic [3:0]  e_pend, e_done, e_clko, e_ce, e_run;

    task automatic model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            m_r[ch] = 4; m_sh[ch] = 4; m_t0[ch] = 0; m_pend[ch] = 0;
        end
        cyc = 0;
        e_pend = '0; e_done = '0; e_clko = '0; e_ce = '0; e_run = 4'hF;
    endtask

    function automatic int unsigned phase(input int ch);
        if (m_r[ch] < 2) return 0;
        return (cyc - m_t0[ch]) % m_r[ch];
    endfunction

    task automatic model_edge();
        for (int ch = 0; ch < NCH; ch++) begin
            bit we, run, app;
            int unsigned p, val;
            we  = cfg_we && (int'(cfg_ch) == ch);
            run = (m_r[ch] >= 2);
            p   = phase(ch);
            e_ce[ch]   = run && (p == 0);
            e_clko[ch] = run && (p < m_r[ch] / 2);
            app = 0;
            val = m_sh[ch];
            if (run && sync_start) begin
                app = m_pend[ch] || we;
                if (we) val = int'(cfg_div);
                m_t0[ch] = cyc + 1;
            end else if (!run || p == m_r[ch] - 1) begin
                app = m_pend[ch];
                m_t0[ch] = cyc + 1;
            end
            if (run && sync_start) m_pend[ch] = 0;
            else if (we)           m_pend[ch] = 1;
            else if (app)          m_pend[ch] = 0;
            if (we)  m_sh[ch] = int'(cfg_div);
            if (app) m_r[ch] = val;
            e_done[ch] = app;
            e_pend[ch] = m_pend[ch];
            e_run[ch]  = (m_r[ch] >= 2);
        end
        cyc++;
    endtask

    // Advance one clock edge, update the model, land 1 ns after the edge.
    task automatic tick();
        @(posedge clki);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit we, input int ch, input int div, input bit sync);
        cfg_we = we; cfg_ch = 2'(ch); cfg_div = 8'(div); sync_start = sync;
    endtask

    task automatic test_reset();
        logic [7:0] pclk, pce;
        pclk = 8'b1100_1100;
        pce  = 8'b1000_1000;
        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        repeat (3) @(posedge clki);
        #1;
        checks++;
        if ({cfg_pend, cfg_done, div_clko, div_ce, ch_run} !== {16'h0, 4'hF}) begin
            errors++;
            $display("FAIL reset_state: got %h exp %h", {cfg_pend, cfg_done, div_clko, div_ce, ch_run}, {16'h0, 4'hF});
        end
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if ({cfg_pend, cfg_done, div_clko, div_ce, ch_run} !== {e_pend, e_done, e_clko, e_ce, e_run}) begin
                errors++;
                $display("FAIL reset_model cyc %0d: got %h exp %h", cyc, {cfg_pend, cfg_done, div_clko, div_ce, ch_run}, {e_pend, e_done, e_clko, e_ce, e_run});
            end
            checks++;
            if (div_clko[0] !== pclk[7-i] || div_ce[0] !== pce[7-i]) begin
                errors++;
                $display("FAIL reset_pattern step %0d: got clko=%b ce=%b exp clko=%b ce=%b", i, div_clko[0], div_ce[0], pclk[7-i], pce[7-i]);
            end
        end
    endtask

    task automatic test_retune_mid();
        bit found;
        found = 0;
        for (int k = 0; k < 8 && !found; k++) begin
            if (phase(1) == 1) found = 1;
            else tick();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL retune_align: got no cnt=1 slot exp one within 8 cycles");
        end
        drive(1, 1, 6, 0);
        tick();
        drive(0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) tick();
            checks++;
            if ({cfg_pend, cfg_done, div_clko, div_ce, ch_run} !== {e_pend, e_done, e_clko, e_ce, e_run}) begin
                errors++;
                $display("FAIL retune cyc %0d: got %h exp %h", cyc, {cfg_pend, cfg_done, div_clko, div_ce, ch_run}, {e_pend, e_done, e_clko, e_ce, e_run});
            end
        end
    endtask

    task automatic test_ratio5();
        logic [9:0] got_ce, got_clko;
        bit seen;
        seen = 0;
        drive(1, 2, 5, 0);
        tick();
        drive(0, 0, 0, 0);
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            seen = e_done[2];
            checks++;
            if ({cfg_pend, cfg_done, div_clko, div_ce, ch_run} !== {e_pend, e_done, e_clko, e_ce, e_run}) begin
                errors++;
                $display("FAIL ratio5_apply cyc %0d: got %h exp %h", cyc, {cfg_pend, cfg_done, div_clko, div_ce, ch_run}, {e_pend, e_done, e_clko, e_ce, e_run});
            end
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            got_ce[9-i]   = div_ce[2];
            got_clko[9-i] = div_clko[2];
        end
        checks++;
        if (!seen || got_ce !== 10'b10000_10000 || got_clko !== 10'b11000_11000) begin
            errors++;
            $display("FAIL ratio5_wave: got applied=%0d ce=%b clko=%b exp applied=1 ce=1000010000 clko=1100011000", seen, got_ce, got_clko);
        end
    endtask

    task automatic test_double_write();
        int dones, ces, highs;
        dones = 0; ces = 0; highs = 0;
        for (int k = 0; k < 6 && phase(3) != 0; k++) tick();
        drive(1, 3, 8, 0);
        tick();
        drive(1, 3, 3, 0);
        tick();
        drive(0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (cfg_done[3] === 1'b1) dones++;
            checks++;
            if ({cfg_pend, cfg_done, div_clko, div_ce, ch_run} !== {e_pend, e_done, e_clko, e_ce, e_run}) begin
                errors++;
                $display("FAIL double_write cyc %0d: got %h exp %h", cyc, {cfg_pend, cfg_done, div_clko, div_ce, ch_run}, {e_pend, e_done, e_clko, e_ce, e_run});
            end
        end
        for (int i = 0; i < 9; i++) begin
            tick();
            if (div_ce[3] === 1'b1) ces++;
            if (div_clko[3] === 1'b1) highs++;
        end
        checks++;
        if (dones != 1 || ces != 3 || highs != 3) begin
            errors++;
            $display("FAIL double_write_result: got dones=%0d ce=%0d high=%0d exp dones=1 ce=3 high=3", dones, ces, highs);
        end
    endtask

    task automatic test_stop_restart();
        int highs;
        highs = 0;
        drive(1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({cfg_pend, cfg_done, div_clko, div_ce, ch_run} !== {e_pend, e_done, e_clko, e_ce, e_run}) begin
                errors++;
                $display("FAIL stop cyc %0d: got %h exp %h", cyc, {cfg_pend, cfg_done, div_clko, div_ce, ch_run}, {e_pend, e_done, e_clko, e_ce, e_run});
            end
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (div_clko[0] !== 1'b0) highs++;
        end
        checks++;
        if (ch_run[0] !== 1'b0 || highs != 0) begin
            errors++;
            $display("FAIL stop_state: got run=%b highs=%0d exp run=0 highs=0", ch_run[0], highs);
        end
        drive(1, 0, 4, 0);
        tick();
        drive(0, 0, 0, 0);
        tick();
        tick();
        checks++;
        if (div_ce[0] !== 1'b1 || ch_run[0] !== 1'b1) begin
            errors++;
            $display("FAIL restart: got ce=%b run=%b exp ce=1 run=1", div_ce[0], ch_run[0]);
        end
    endtask

    task automatic test_sync();
        drive(1, 1, 3, 0);
        tick();
        drive(1, 2, 4, 0);
        tick();
        drive(0, 0, 0, 0);
        repeat (14 + $urandom_range(0, 2)) tick();
        checks++;
        if ({cfg_pend, cfg_done, div_clko, div_ce, ch_run} !== {e_pend, e_done, e_clko, e_ce, e_run}) begin
            errors++;
            $display("FAIL sync_pre cyc %0d: got %h exp %h", cyc, {cfg_pend, cfg_done, div_clko, div_ce, ch_run}, {e_pend, e_done, e_clko, e_ce, e_run});
        end
        drive(0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0);
        tick();
        checks++;
        if (div_ce[2:1] !== 2'b11 || div_ce !== e_ce) begin
            errors++;
            $display("FAIL sync_align: got ce=%b exp ce=%b with ch1/ch2 both set", div_ce, e_ce);
        end
    endtask

    task automatic test_collisions();
        bit found;
        found = 0;
        drive(1, 1, 5, 1);
        tick();
        drive(0, 0, 0, 0);
        checks++;
        if (cfg_done[1] !== 1'b1 || cfg_pend[1] !== 1'b0 || cfg_done !== e_done) begin
            errors++;
            $display("FAIL we_with_sync: got done=%b pend=%b exp done=%b pend[1]=0", cfg_done, cfg_pend, e_done);
        end
        drive(1, 2, 6, 0);
        tick();
        drive(0, 0, 0, 0);
        for (int k = 0; k < 12 && !found; k++) begin
            if (m_pend[2] && phase(2) == m_r[2] - 1) found = 1;
            else tick();
        end
        drive(1, 2, 3, 0);
        tick();
        drive(0, 0, 0, 0);
        checks++;
        if (!found || cfg_done[2] !== 1'b1 || cfg_pend[2] !== 1'b1) begin
            errors++;
            $display("FAIL we_on_apply: got found=%0d done=%b pend=%b exp found=1 done=1 pend=1", found, cfg_done[2], cfg_pend[2]);
        end
        for (int i = 0; i < 14; i++) begin
            tick();
            checks++;
            if ({cfg_pend, cfg_done, div_clko, div_ce, ch_run} !== {e_pend, e_done, e_clko, e_ce, e_run}) begin
                errors++;
                $display("FAIL collide cyc %0d: got %h exp %h", cyc, {cfg_pend, cfg_done, div_clko, div_ce, ch_run}, {e_pend, e_done, e_clko, e_ce, e_run});
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) == 0, int'($urandom % 4), int'($urandom % 11), ($urandom % 40) == 0);
            tick();
            checks++;
            if ({cfg_pend, cfg_done, div_clko, div_ce, ch_run} !== {e_pend, e_done, e_clko, e_ce, e_run}) begin
                errors++;
                $display("FAIL random cyc %0d: got %h exp %h", cyc, {cfg_pend, cfg_done, div_clko, div_ce, ch_run}, {e_pend, e_done, e_clko, e_ce, e_run});
            end
        end
        drive(0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        for (int ch = 0; ch < NCH; ch++) begin
            drive(1, ch, 3 + ch, 0);
            tick();
        end
        drive(0, 0, 0, 0);
        repeat (12 + $urandom_range(0, 3)) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cfg_pend, cfg_done, div_clko, div_ce, ch_run} !== {16'h0, 4'hF}) begin
            errors++;
            $display("FAIL reset_async: got %h exp %h", {cfg_pend, cfg_done, div_clko, div_ce, ch_run}, {16'h0, 4'hF});
        end
        @(posedge clki);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if ({cfg_pend, cfg_done, div_clko, div_ce, ch_run} !== {e_pend, e_done, e_clko, e_ce, e_run}) begin
                errors++;
                $display("FAIL reset_restart cyc %0d: got %h exp %h", cyc, {cfg_pend, cfg_done, div_clko, div_ce, ch_run}, {e_pend, e_done, e_clko, e_ce, e_run});
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_retune_mid();
        test_ratio5();
        test_double_write();
        test_stop_restart();
        test_sync();
        test_collisions();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
